edid_reader: RTL and testbench
==============================

# edid_reader

DDC/EDID master reader: an I2C initiator that fetches a block of bytes from an EDID responder at 7-bit address 0x50 (0xA0 write / 0xA1 read) and streams them out one byte per strobe. It is the initiator counterpart to the EDID slave and drives the open-drain DDC lines through enables. It lets the design read a sink's EDID (downstream monitor) and serves as the in-house stimulus generator for slave benches.

## Interface

Parameters:
- `CLK_DIV`, default 125: clk cycles per SCL quarter-period. 100 MHz gives 200 kHz SCL. Legal range 4..1023.

Ports:
- `clk` in 1: system clock. All logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request pulse. Sampled only when `busy`=0.
- `word_addr` in 8: first EDID offset. Latched on accepted `start`.
- `byte_count` in 8: bytes to read. 0 means 256. Latched on accepted `start`.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse at end of the transaction, success or error.
- `ack_err` out 1: valid with `done`. High if the responder NACKed the address or word byte. Held until the next accepted `start`.
- `rd_data` out 8: received byte. MSB is received first.
- `rd_valid` out 1: one-cycle strobe per received byte.
- `scl_oe` out 1: 1 pulls SCL low, 0 releases it.
- `sda_oe` out 1: 1 pulls SDA low, 0 releases it.
- `sda_i` in 1: SDA line level, already synchronised externally.
- `chksum_err` out 1: see Configuration. Valid with `done`.

## Operation

- The bit engine runs on a quarter-period tick counter. The counter counts 0..CLK_DIV-1 and ticks at CLK_DIV-1.
- Each bit takes 4 ticks:
  - Q0: set SDA with SCL low.
  - Q1: release SCL.
  - Q2: sample `sda_i` while SCL is high.
  - Q3: pull SCL low.
- Transaction FSM states: IDLE → START → ADDR_W → ACK1 → WADDR → ACK2 → RSTART → ADDR_R → ACK3 → READ → MACK → STOP → IDLE.
- START and RSTART: SDA falls while SCL is high, then SCL goes low.
- STOP: SDA rises while SCL is high.
- Write bytes (0xA0, `word_addr`, 0xA1) shift out MSB first. In the ACK slot, SDA is released and sampled at Q2.
- A NACK (sample=1) in ACK1, ACK2 or ACK3 sets `ack_err` and jumps to STOP. No bytes are strobed.
- READ: SDA is released and 8 bits are sampled MSB first.
- `rd_valid` pulses in the clk cycle after the 8th sample, together with `rd_data`.
- MACK: SDA is driven low (ACK) when bytes remain; it is released (NACK) after the last byte. Then go to STOP.
- The remaining-byte counter is 9 bits. It is loaded with `byte_count`, or with 256 when `byte_count` is 0, and decrements on each `rd_valid`.
- `done` pulses in the cycle the FSM re-enters IDLE.
- `start` while `busy`=1 is ignored. `start` in the same cycle as `done` is ignored; it is accepted from the next cycle.
- No clock stretching: SCL is never read back.
- No arbitration: the block is the only master on the bus.

## Timing

- Reset values:
  - `busy`, `done`, `ack_err`, `rd_valid`, `chksum_err`, `scl_oe`, `sda_oe` = 0, so both lines are released.
  - `rd_data` = 0x00.
  - FSM = IDLE; tick counter = 0.
- `rst` in mid-transaction:
  - Next cycle: both lines are released and the FSM is in IDLE.
  - No STOP is generated and `done` does not pulse.
- Latency:
  - `busy` rises in the cycle after `start`.
  - The first SDA fall (START) happens 1 quarter after `busy` rises.
- Transaction length:
  - Header: 3 bytes × 9 bits plus START and RSTART, about (27+2)×4 quarters.
  - Each read byte: 9 bits × 4 quarters.
  - STOP: 2 quarters.
- Wrap-around: the responder auto-increments past 0xFF to 0x00. The reader does not care and simply counts bytes.

## Configuration

- `EDID_READER_CHKSUM_EN` defined:
  - An 8-bit sum accumulates every strobed byte. It clears on accepted `start` and at every 128-byte boundary.
  - At each boundary (and at `done`, if `byte_count` is a multiple of 128) a non-zero sum sets sticky `chksum_err`.
  - `chksum_err` clears on accepted `start`.
- Undefined: no accumulator is built and `chksum_err` is tied to 0.

## Test plan

- Responder model holds an EDID image with bytes 0..7 = 00 FF FF FF FF FF FF 00. Stimulus: `start`, `word_addr`=0x00, `byte_count`=8.
  - Exactly 8 `rd_valid` strobes with those values.
  - NACK on the 8th MACK slot.
  - `done` with `ack_err`=0.
- No responder present (SDA pulled up).
  - `ack_err`=1 at `done` after the ACK1 slot.
  - Zero `rd_valid`.
  - A STOP is seen on the bus.
- `byte_count`=0, `word_addr`=0x80.
  - 256 strobes, wrapping through offset 0xFF → 0x00.
  - With `EDID_READER_CHKSUM_EN` and a valid image: `chksum_err`=0.
  - With byte 0x85 corrupted by +1: `chksum_err`=1.
- `rst` asserted during READ bit 3.
  - Next cycle `scl_oe`=`sda_oe`=0 and `busy`=0.
  - No `done` pulse.
  - A following `start` completes normally.
- `start` pulsed while `busy`, and in the `done` cycle: both are ignored. The bus shows exactly one transaction.
- `CLK_DIV`=4 with a bus monitor:
  - SCL period = 16 clk.
  - SDA only changes while SCL is low, except at START, RSTART and STOP.

Source files
------------

// File: rtl/edid_reader.sv
// rtl/edid_reader.sv - DDC/EDID I2C master: reads a byte block from responder 0x50 and strobes it out
// Define EDID_READER_CHKSUM_EN to build the per-128-byte block checksum check behind chksum_err.

module edid_reader #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] word_addr,
  input  logic [7:0] byte_count,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i,
  output logic       chksum_err
);

  localparam logic [9:0] CNT_MAX = 10'(CLK_DIV - 1);

  // Order matters: each data/read state is immediately followed by its acknowledge slot.
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ACK1, S_WADDR, S_ACK2, S_RSTART,
    S_ADDR_R, S_ACK3, S_READ, S_MACK, S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [1:0]  q_q, q_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        samp_q, samp_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  addr_q, addr_d;
  logic        ack_err_q, ack_err_d;
  logic        done_q, done_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        tick;
  logic        accept;
  logic        scl_low;

  assign tick     = (state_q != S_IDLE) && (cnt_q == CNT_MAX);
  assign accept   = start && (state_q == S_IDLE) && !done_q;
  assign scl_low  = (q_q == 2'd0) || (q_q == 2'd3);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign ack_err  = ack_err_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      q_q        <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      samp_q     <= 1'b0;
      rem_q      <= '0;
      addr_q     <= '0;
      ack_err_q  <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      ack_err_q  <= ack_err_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    ack_err_d  = ack_err_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    if (state_q == S_IDLE) begin
      cnt_d = '0;
      q_d   = '0;
      if (accept) begin
        state_d   = S_START;
        addr_d    = word_addr;
        rem_d     = (byte_count == 8'd0) ? 9'd256 : {1'b0, byte_count};
        ack_err_d = 1'b0;
      end
    end else begin
      cnt_d = tick ? 10'd0 : cnt_q + 10'd1;
      if (tick) q_d = q_q + 2'd1;
    end

    // SCL is high during Q2, so every bus sample is taken at its closing tick.
    if (tick && q_q == 2'd2) begin
      samp_d = sda_i;
      if (state_q == S_READ) begin
        shift_d = {shift_q[6:0], sda_i};
        if (bit_q == 3'd7) begin
          rd_valid_d = 1'b1;
          rd_data_d  = {shift_q[6:0], sda_i};
          rem_d      = rem_q - 9'd1;
        end
      end
    end

    // STOP is two quarters long; SDA rises as the FSM lands in IDLE.
    if (tick && q_q == 2'd1 && state_q == S_STOP) begin
      state_d = S_IDLE;
      q_d     = '0;
      done_d  = 1'b1;
    end

    if (tick && q_q == 2'd3) begin
      case (state_q)
        S_START: begin
          state_d = S_ADDR_W;
          shift_d = 8'hA0;
          bit_d   = '0;
        end
        S_ADDR_W, S_WADDR, S_ADDR_R, S_READ: begin
          if (bit_q == 3'd7) state_d = state_t'(state_q + 4'd1);
          else               bit_d   = bit_q + 3'd1;
          if (state_q != S_READ) shift_d = {shift_q[6:0], 1'b0};
        end
        S_ACK1: begin
          if (samp_q) begin
            ack_err_d = 1'b1;
            state_d   = S_STOP;
          end else begin
            state_d = S_WADDR;
            shift_d = addr_q;
            bit_d   = '0;
          end
        end
        S_ACK2: begin
          if (samp_q) begin
            ack_err_d = 1'b1;
            state_d   = S_STOP;
          end else begin
            state_d = S_RSTART;
          end
        end
        S_RSTART: begin
          state_d = S_ADDR_R;
          shift_d = 8'hA1;
          bit_d   = '0;
        end
        S_ACK3: begin
          if (samp_q) begin
            ack_err_d = 1'b1;
            state_d   = S_STOP;
          end else begin
            state_d = S_READ;
            bit_d   = '0;
          end
        end
        S_MACK: begin
          if (rem_q != 9'd0) begin
            state_d = S_READ;
            bit_d   = '0;
          end else begin
            state_d = S_STOP;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_q)
      S_START: begin
        scl_oe = (q_q == 2'd3);
        sda_oe = (q_q != 2'd0);
      end
      S_ADDR_W, S_WADDR, S_ADDR_R: begin
        scl_oe = scl_low;
        sda_oe = ~shift_q[7];
      end
      S_ACK1, S_ACK2, S_ACK3, S_READ: scl_oe = scl_low;
      S_MACK: begin
        scl_oe = scl_low;
        sda_oe = (rem_q != 9'd0);
      end
      // Release SDA while SCL is low, then drop it during the high phase.
      S_RSTART: begin
        scl_oe = scl_low;
        sda_oe = q_q[1];
      end
      S_STOP: begin
        scl_oe = (q_q == 2'd0);
        sda_oe = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef EDID_READER_CHKSUM_EN
  logic [7:0] sum_q, sum_d, sum_nx;
  logic [6:0] blk_q, blk_d;
  logic       chk_q, chk_d;

  // Each EDID block of 128 bytes must sum to zero modulo 256.
  always_comb begin
    sum_nx = sum_q + rd_data_q;
    sum_d  = sum_q;
    blk_d  = blk_q;
    chk_d  = chk_q;
    if (accept) begin
      sum_d = '0;
      blk_d = '0;
      chk_d = 1'b0;
    end else if (rd_valid_q) begin
      blk_d = blk_q + 7'd1;
      if (blk_q == 7'd127) begin
        sum_d = '0;
        if (sum_nx != 8'd0) chk_d = 1'b1;
      end else begin
        sum_d = sum_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      blk_q <= '0;
      chk_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      blk_q <= blk_d;
      chk_q <= chk_d;
    end
  end

  assign chksum_err = chk_q;
`else
  assign chksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_edid_reader.sv
// tb/tb_edid_reader.sv - directed bench for edid_reader with an EDID responder model and bus monitor
// Expects chksum_err=1 on the corrupted block only when EDID_READER_CHKSUM_EN is defined.

module tb_edid_reader;

  localparam int CLK_DIV = 4;
  localparam int SCL_PER = 4 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] word_addr = '0;
  logic [7:0] byte_count = '0;
  logic       busy, done, ack_err, rd_valid, scl_oe, sda_oe, chksum_err;
  logic [7:0] rd_data;
  logic       slv_oe = 1'b0;
  logic       sda_i;

  assign sda_i = ~(sda_oe | slv_oe);

  always #5 clk = ~clk;

  edid_reader #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_addr  (word_addr),
    .byte_count (byte_count),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .sda_i      (sda_i),
    .chksum_err (chksum_err)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0] mem [256];
  logic       present = 1'b1;
  logic [7:0] rx [$];
  int n_start = 0, n_stop = 0, n_rise = 0, n_badp = 0;
  int n_mack = 0, n_mnack = 0, n_done = 0;
  int cyc = 0, last_rise = -1;
  logic pscl = 1'b1, psda = 1'b1;
  int s_mode = 0, s_bit = 0, s_txi = 0;
  logic [7:0] s_sh = '0, s_ptr = '0, s_tx = '0;
  logic s_mack = 1'b0;

  // Bus monitor plus responder: modes 0 idle, 1 rx address, 2 rx word, 3 wait restart, 4 transmit.
  always @(negedge clk) begin
    logic l_scl, l_sda;
    l_scl = ~scl_oe;
    l_sda = sda_i;
    cyc++;
    if (rd_valid) rx.push_back(rd_data);
    if (done) n_done++;
    if (busy) begin
      if (!pscl && l_scl) begin
        n_rise++;
        if (last_rise >= 0 && cyc - last_rise != SCL_PER) n_badp++;
        last_rise = cyc;
      end
    end else begin
      last_rise = -1;
    end
    if (pscl && l_scl && psda && !l_sda) n_start++;
    if (pscl && l_scl && !psda && l_sda) n_stop++;

    if (rst) begin
      s_mode = 0;
      slv_oe = 1'b0;
    end else if (pscl && l_scl && psda && !l_sda) begin
      s_mode = present ? 1 : 0;
      s_bit  = 0;
      slv_oe = 1'b0;
    end else if (pscl && l_scl && !psda && l_sda) begin
      s_mode = 0;
      slv_oe = 1'b0;
    end else if (!pscl && l_scl) begin
      if ((s_mode == 1 || s_mode == 2) && s_bit < 8) begin
        s_sh = {s_sh[6:0], l_sda};
        s_bit++;
      end
      if (s_mode == 4 && s_txi == 9) begin
        s_mack = !l_sda;
        if (!l_sda) n_mack++;
        else n_mnack++;
      end
    end else if (pscl && !l_scl) begin
      if (s_mode == 1 || s_mode == 2) begin
        if (s_bit == 8) begin
          s_bit = 9;
          if (s_mode == 1 && s_sh[7:1] != 7'h50) s_mode = 0;
          else slv_oe = 1'b1;
        end else if (s_bit == 9) begin
          slv_oe = 1'b0;
          if (s_mode == 2) begin
            s_ptr  = s_sh;
            s_mode = 3;
          end else if (s_sh[0]) begin
            s_mode = 4;
            s_tx   = mem[s_ptr];
            slv_oe = ~s_tx[7];
            s_txi  = 1;
          end else begin
            s_mode = 2;
            s_bit  = 0;
          end
        end
      end else if (s_mode == 4) begin
        if (s_txi < 8) begin
          slv_oe = ~s_tx[7 - s_txi];
          s_txi++;
        end else if (s_txi == 8) begin
          slv_oe = 1'b0;
          s_txi  = 9;
          s_ptr  = s_ptr + 8'd1;
        end else if (s_mack) begin
          s_tx   = mem[s_ptr];
          slv_oe = ~s_tx[7];
          s_txi  = 1;
        end else begin
          s_mode = 0;
        end
      end
    end
    pscl = l_scl;
    psda = l_sda;
  end

  task automatic clr_mon();
    rx.delete();
    n_start = 0; n_stop = 0; n_rise = 0; n_badp = 0;
    n_mack = 0; n_mnack = 0;
  endtask

  task automatic pulse_start(input logic [7:0] a, input logic [7:0] c);
    word_addr  = a;
    byte_count = c;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(output logic ae, output logic ce);
    logic got;
    got = 1'b0;
    ae  = 1'b0;
    ce  = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        ae  = ack_err;
        ce  = chksum_err;
        break;
      end
    end
    check("done_seen", got, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_rx(input int a, input int n);
    int bad;
    bad = 0;
    check("rx_count", rx.size(), n);
    for (int i = 0; i < rx.size(); i++)
      if (rx[i] !== mem[(a + i) % 256]) bad++;
    check("rx_data_errs", bad, 0);
  endtask

  logic [7:0] exp8 [8];
  logic       ae, ce, found;
  logic [7:0] s;
  int         d0;

  initial begin
    exp8 = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    for (int i = 0; i < 256; i++) mem[i] = (i < 128) ? 8'(i * 3 + 1) : 8'(i ^ 8'h5A);
    for (int i = 0; i < 8; i++) mem[i] = exp8[i];
    for (int b = 0; b < 2; b++) begin
      s = '0;
      for (int i = 0; i < 127; i++) s = s + mem[b * 128 + i];
      mem[b * 128 + 127] = 8'(-s);
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_chksum_err", chksum_err, 1'b0);
    check("rst_lines", {scl_oe, sda_oe}, 2'b00);

    // 8-byte header read with start latency
    clr_mon();
    pulse_start(8'h00, 8'd8);
    check("busy_rise", busy, 1'b1);
    repeat (3) @(negedge clk);
    check("sda_before_start", sda_oe, 1'b0);
    @(negedge clk);
    check("start_sda_fall", sda_oe, 1'b1);
    wait_done(ae, ce);
    check("hdr_ack_err", ae, 1'b0);
    check("hdr_rx_count", rx.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < rx.size()) check($sformatf("hdr_byte%0d", i), rx[i], exp8[i]);
    check("hdr_mack", n_mack, 7);
    check("hdr_mnack", n_mnack, 1);
    check("hdr_starts", n_start, 2);
    check("hdr_stops", n_stop, 1);
    check("hdr_scl_rises", n_rise, 101);
    check("hdr_scl_period_errs", n_badp, 0);
    check("hdr_busy_after", busy, 1'b0);

    // no responder: NACK on the address byte
    present = 1'b0;
    clr_mon();
    pulse_start(8'h00, 8'd8);
    wait_done(ae, ce);
    check("nack_ack_err", ae, 1'b1);
    check("nack_rx_count", rx.size(), 0);
    check("nack_starts", n_start, 1);
    check("nack_stops", n_stop, 1);
    check("nack_scl_rises", n_rise, 10);
    present = 1'b1;

    // start while busy and in the done cycle are ignored
    clr_mon();
    d0 = n_done;
    pulse_start(8'h10, 8'd1);
    repeat (200) @(negedge clk);
    pulse_start(8'h40, 8'd4);
    found = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        pulse_start(8'h40, 8'd4);
        break;
      end
    end
    check("ign_done_seen", found, 1'b1);
    repeat (300) @(negedge clk);
    check("ign_busy", busy, 1'b0);
    check("ign_done_count", n_done - d0, 1);
    check("ign_starts", n_start, 2);
    check("ign_stops", n_stop, 1);
    check("ign_rx_count", rx.size(), 1);
    if (rx.size() > 0) check("ign_byte", rx[0], 8'h31);

    // reset in the middle of a read byte
    clr_mon();
    pulse_start(8'h00, 8'd8);
    found = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (s_mode == 4 && s_txi == 4) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_read_reached", found, 1'b1);
    d0  = n_done;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_lines", {scl_oe, sda_oe}, 2'b00);
    check("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_rst_no_done", n_done - d0, 0);
    clr_mon();
    pulse_start(8'h00, 8'd8);
    wait_done(ae, ce);
    check("after_rst_ack_err", ae, 1'b0);
    check_rx(0, 8);

    // 256-byte read wrapping through 0xFF -> 0x00
    clr_mon();
    pulse_start(8'h80, 8'd0);
    wait_done(ae, ce);
    check("full_ack_err", ae, 1'b0);
    check("full_chksum_err", ce, 1'b0);
    check_rx(8'h80, 256);
    if (rx.size() == 256) begin
      check("full_first", rx[0], 8'hDA);
      check("full_wrap", rx[128], 8'h00);
      check("full_wrap_next", rx[129], 8'hFF);
    end
    check("full_mack", n_mack, 255);
    check("full_mnack", n_mnack, 1);

    // corrupted second block
    mem[8'h85] = mem[8'h85] + 8'd1;
    clr_mon();
    pulse_start(8'h80, 8'd128);
    wait_done(ae, ce);
`ifdef EDID_READER_CHKSUM_EN
    check("bad_chksum_err", ce, 1'b1);
`else
    check("bad_chksum_err", ce, 1'b0);
`endif
    check("bad_rx_count", rx.size(), 128);
    mem[8'h85] = mem[8'h85] - 8'd1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
